// File: rtl/keypad_entry_pkg.sv
// Shared types, key codes and small helpers for the keypad entry block.
package keypad_entry_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_CLR  = 4'hA;
  localparam logic [3:0] KEY_BSP  = 4'hB;
  localparam logic [3:0] ROW_IDLE = 4'b1110;

  // Active-low row drive with a single low bit at idx
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    row_drive = ~(4'b0001 << idx);
  endfunction

  // Index of the lowest-numbered low column
  function automatic logic [1:0] first_low(input logic [3:0] c);
    if (!c[0])      first_low = 2'd0;
    else if (!c[1]) first_low = 2'd1;
    else if (!c[2]) first_low = 2'd2;
    else            first_low = 2'd3;
  endfunction

  // Digit entry register update for one accepted key
  function automatic logic [15:0] bcd_next(input logic [15:0] b, input logic [3:0] k);
    if (k <= 4'd9)        bcd_next = {b[11:0], k};
    else if (k == KEY_CLR) bcd_next = 16'h0000;
    else if (k == KEY_BSP) bcd_next = {4'h0, b[15:4]};
    else                   bcd_next = b;
  endfunction

endpackage

// File: rtl/keypad_entry_scan_tick.sv
// Free-running prescaler producing a one-cycle tick every SCAN_DIV clocks.
module scan_tick #(
  parameter int unsigned SCAN_DIV = 65536
) (
  input  logic clk,
  input  logic clr_n,
  output logic tick
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;

  // Count 0..SCAN_DIV-1 and flag the wrap as a registered tick
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CW'(SCAN_DIV - 1));
      if (cnt == CW'(SCAN_DIV - 1)) cnt <= '0;
      else                          cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce and a four-digit BCD entry register.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 65536,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] bcd,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int unsigned DW  = $clog2(DEBOUNCE_CNT + 1);
  // Debounce ticks after the initial scan hit needed to accept a press
  localparam int unsigned ACC = (DEBOUNCE_CNT > 1) ? DEBOUNCE_CNT - 1 : 1;

  logic          tick;
  logic [3:0]    col_m;
  logic [3:0]    col_s;
  state_t        state;
  logic [1:0]    row_idx;
  logic [1:0]    cand_c;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_inc;
  logic [3:0]    cand_code;

  assign dcnt_inc  = dcnt + DW'(1);
  assign cand_code = {row_idx, cand_c};

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .clk   (clk),
    .clr_n (clr_n),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous column lines
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= col;
      col_s <= col_m;
    end
  end

  // Scan/debounce/hold/release controller, advanced only on ticks
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= ST_SCAN;
      row_idx   <= 2'd0;
      row       <= ROW_IDLE;
      cand_c    <= 2'd0;
      dcnt      <= '0;
      bcd       <= 16'h0000;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        unique case (state)
          ST_SCAN: begin
            if (&col_s) begin
              row_idx <= row_idx + 2'd1;
              row     <= row_drive(row_idx + 2'd1);
            end else begin
              cand_c <= first_low(col_s);
              dcnt   <= '0;
              state  <= ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            if (!col_s[cand_c]) begin
              if (dcnt_inc == DW'(ACC)) begin
                state     <= ST_HOLD;
                key_valid <= 1'b1;
                key_code  <= cand_code;
                bcd       <= bcd_next(bcd, cand_code);
              end else begin
                dcnt <= dcnt_inc;
              end
            end else begin
              state   <= ST_SCAN;
              row_idx <= row_idx + 2'd1;
              row     <= row_drive(row_idx + 2'd1);
            end
          end
          ST_HOLD: begin
            if (col_s[cand_c]) begin
              dcnt  <= '0;
              state <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (&col_s) begin
              if (dcnt_inc == DW'(DEBOUNCE_CNT)) begin
                state   <= ST_SCAN;
                row_idx <= row_idx + 2'd1;
                row     <= row_drive(row_idx + 2'd1);
              end else begin
                dcnt <= dcnt_inc;
              end
            end else begin
              state <= ST_HOLD;
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter SCAN_DIV, default 65536; clk cycles per scan tick (row dwell), min 4.
REQ-002 Parameter DEBOUNCE_CNT, default 4; consecutive matching ticks needed to accept press/release, min 1.
REQ-003 clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-004 clr_n  input  1  reset, asynchronous, active-low.
REQ-005 col  input  4  keypad column lines, active-low, asynchronous to clk.
REQ-006 row  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-007 bcd  output  16  four entered BCD digits, [15:12] oldest, [3:0] newest; feeds display driver data input.
REQ-008 key_code  output  4  code of last accepted key.
REQ-009 key_valid  output  1  one-cycle pulse per accepted key.

Function
REQ-010 col SHALL pass a 2-flop synchronizer before any use.
REQ-011 A prescaler SHALL assert a one-cycle tick every SCAN_DIV clks; free-running, never reset except by clr_n.
REQ-012 Key code SHALL be 4*r + c (r = index of low row bit, c = column index); codes 0-9 digits, 0xA clear, 0xB backspace, 0xC-0xF no-op.
REQ-013 FSM states: SCAN, DEBOUNCE, HOLD, RELEASE.
REQ-014 SCAN: on tick, if all synced col high, rotate row low bit to next index (3 wraps to 0); else latch candidate (r, lowest-index low c), keep row, clear debounce count, go DEBOUNCE.
REQ-015 DEBOUNCE: on tick, if candidate column low, count++; on count reaching DEBOUNCE_CNT-1 (i.e. DEBOUNCE_CNT total matching samples incl. the SCAN sample) accept key and go HOLD; if column high, go SCAN and advance row.
REQ-016 Accept: in the clk after the accepting tick, key_valid=1 for exactly one cycle, key_code=code, bcd updated in the same cycle.
REQ-017 bcd update: digit d -> {bcd[11:0], d} (oldest digit dropped); 0xA -> 0; 0xB -> {4'h0, bcd[15:4]}; 0xC-0xF -> unchanged.
REQ-018 HOLD: row held; on tick with candidate column high, clear count, go RELEASE; else stay (no auto-repeat).
REQ-019 RELEASE: on tick with all col high, count++; reaching DEBOUNCE_CNT go SCAN and advance row; any col low returns to HOLD.
REQ-020 Other keys pressed while in DEBOUNCE/HOLD/RELEASE SHALL be ignored except as REQ-019 low-col abort.
REQ-021 Ticks SHALL be the only events advancing FSM; no transition between ticks.

Reset
REQ-022 clr_n low SHALL immediately force: state SCAN, row=4'b1110, bcd=16'h0000, key_code=4'h0, key_valid=0, counts and prescaler 0, synchronizer flops 1.
REQ-023 Reset mid-press SHALL discard candidate; key still held after release of reset SHALL be re-debounced and accepted once.

Structure
REQ-024 Shared package SHALL hold FSM state enum and key-code constants (KEY_CLR=0xA, KEY_BSP=0xB).
REQ-025 One sub-module: scan_tick (prescaler, SCAN_DIV parameter, clk/clr_n in, tick out).

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, keypad model shorts row to col)
REQ-026 Reset release, no keys -> row cycles 1110,1101,1011,0111,1110 every 4 clks; key_valid never asserted.
REQ-027 Press r0c1, hold 40 clks, release; then r1c1, r2c0 (digits 1,5,8) -> bcd=16'h0158, three key_valid pulses, key_code=8.
REQ-028 Enter 1,2,3,4,5 -> bcd=16'h2345; then key 0xB -> 16'h0234; then 0xA -> 16'h0000.
REQ-029 Press key 7 for only 2 ticks -> no key_valid, bcd unchanged, scanning resumes.
REQ-030 Hold key 9 for 200 clks with 1-tick bounce on release -> exactly one key_valid pulse.
REQ-031 Assert clr_n low during HOLD with bcd=16'h0012, key still held -> bcd=0, row=1110 at once; after release of reset key accepted once, bcd=16'h000<key>.
